bank_conflict_arbiter: RTL and testbench

- Sits between the 8 LSUs and the 8 bank groups, in front of the bank-side address path.
- Each LSU presents {bank_sel[2:0], addr} on its address bus. The block grants at most one LSU per bank per cycle, using an independent round-robin pointer per bank, and stalls the losers via ready.
- Granted addresses are registered onto conflict-free per-bank outputs, tagged with the source port for the read-return path.

---
 rtl/bank_conflict_arbiter_if.sv | 69 ++++++
 rtl/bank_conflict_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bank_conflict_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bank_conflict_arbiter_if.sv
// Bundles the LSU-side request bus and the bank-side output bus.
// The master modport is the environment (LSUs and banks); the arbiter takes the slave side.
// A_W and A_bus get defaults here when the build does not define them.
`ifndef A_W
`define A_W 16
`endif
`ifndef A_bus
`define A_bus (`A_W+3)
`endif

interface bank_conflict_arbiter_if #(
  parameter int ADDR_W = `A_W,
  parameter int BUS_W  = ADDR_W + 3
);
  logic [7:0]        req_valid;
  logic [BUS_W-1:0]  req_addr_bus_0;
  logic [BUS_W-1:0]  req_addr_bus_1;
  logic [BUS_W-1:0]  req_addr_bus_2;
  logic [BUS_W-1:0]  req_addr_bus_3;
  logic [BUS_W-1:0]  req_addr_bus_4;
  logic [BUS_W-1:0]  req_addr_bus_5;
  logic [BUS_W-1:0]  req_addr_bus_6;
  logic [BUS_W-1:0]  req_addr_bus_7;
  logic [7:0]        req_ready;
  logic [7:0]        bank_busy;
  logic [7:0]        bank_valid;
  logic [ADDR_W-1:0] bank_addr_0;
  logic [ADDR_W-1:0] bank_addr_1;
  logic [ADDR_W-1:0] bank_addr_2;
  logic [ADDR_W-1:0] bank_addr_3;
  logic [ADDR_W-1:0] bank_addr_4;
  logic [ADDR_W-1:0] bank_addr_5;
  logic [ADDR_W-1:0] bank_addr_6;
  logic [ADDR_W-1:0] bank_addr_7;
  logic [2:0]        bank_src_0;
  logic [2:0]        bank_src_1;
  logic [2:0]        bank_src_2;
  logic [2:0]        bank_src_3;
  logic [2:0]        bank_src_4;
  logic [2:0]        bank_src_5;
  logic [2:0]        bank_src_6;
  logic [2:0]        bank_src_7;

  modport master (
    output req_valid,
    output req_addr_bus_0, req_addr_bus_1, req_addr_bus_2, req_addr_bus_3,
    output req_addr_bus_4, req_addr_bus_5, req_addr_bus_6, req_addr_bus_7,
    output bank_busy,
    input  req_ready,
    input  bank_valid,
    input  bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3,
    input  bank_addr_4, bank_addr_5, bank_addr_6, bank_addr_7,
    input  bank_src_0, bank_src_1, bank_src_2, bank_src_3,
    input  bank_src_4, bank_src_5, bank_src_6, bank_src_7
  );

  modport slave (
    input  req_valid,
    input  req_addr_bus_0, req_addr_bus_1, req_addr_bus_2, req_addr_bus_3,
    input  req_addr_bus_4, req_addr_bus_5, req_addr_bus_6, req_addr_bus_7,
    input  bank_busy,
    output req_ready,
    output bank_valid,
    output bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3,
    output bank_addr_4, bank_addr_5, bank_addr_6, bank_addr_7,
    output bank_src_0, bank_src_1, bank_src_2, bank_src_3,
    output bank_src_4, bank_src_5, bank_src_6, bank_src_7
  );
endinterface

// File: rtl/bank_conflict_arbiter.sv
// bank_conflict_arbiter: 8 LSUs x 8 banks, one grant per bank per cycle,
// independent round-robin pointer per bank, losers stalled through req_ready.
// Granted addresses are registered onto per-bank outputs tagged with the source port.
// Optional stall counters per port are built when BANK_ARB_PERF_EN is defined.
`ifndef A_W
`define A_W 16
`endif
`ifndef A_bus
`define A_bus (`A_W+3)
`endif

module bank_conflict_arbiter #(
  parameter int ADDR_W = `A_W,
  parameter int BUS_W  = ADDR_W + 3,
  parameter int NUM_P  = 8
) (
  input logic clk,
  input logic rst,
  bank_conflict_arbiter_if.slave bus
`ifdef BANK_ARB_PERF_EN
  ,
  input  logic         perf_clr,
  output logic [127:0] perf_stall_cnt
`endif
);

  // Port/bank count is hard-wired to 8 with a 3-bit select.
  if (NUM_P != 8) begin : g_num_p_check
    $error("bank_conflict_arbiter: NUM_P must be 8");
  end
  if (BUS_W != ADDR_W + 3) begin : g_bus_w_check
    $error("bank_conflict_arbiter: BUS_W must be ADDR_W+3");
  end
  if (BUS_W != `A_bus) begin : g_bus_macro_check
    $error("bank_conflict_arbiter: BUS_W must equal A_bus");
  end

  logic [BUS_W-1:0]  bus_in [8];
  logic [2:0]        sel    [8];
  logic [ADDR_W-1:0] addr   [8];
  logic [7:0]        cand   [8];   // cand[b][i]: port i requests bank b
  logic [7:0]        grant;
  logic [2:0]        win    [8];
  logic [7:0]        ready;
  logic [2:0]        rr_ptr [8];

  logic [7:0]        out_valid;
  logic [ADDR_W-1:0] out_addr [8];
  logic [2:0]        out_src  [8];

  assign bus_in[0] = bus.req_addr_bus_0;
  assign bus_in[1] = bus.req_addr_bus_1;
  assign bus_in[2] = bus.req_addr_bus_2;
  assign bus_in[3] = bus.req_addr_bus_3;
  assign bus_in[4] = bus.req_addr_bus_4;
  assign bus_in[5] = bus.req_addr_bus_5;
  assign bus_in[6] = bus.req_addr_bus_6;
  assign bus_in[7] = bus.req_addr_bus_7;

  // Split each LSU bus into bank select and bank-local address.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sel[i]  = bus_in[i][BUS_W-1:ADDR_W];
      addr[i] = bus_in[i][ADDR_W-1:0];
    end
  end

  // Build the per-bank candidate sets from valid requests.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      cand[b] = '0;
      for (int i = 0; i < 8; i++) begin
        cand[b][i] = bus.req_valid[i] && (sel[i] == 3'(b));
      end
    end
  end

  // Round-robin pick per bank, scanning upward from the pointer with wrap; busy banks grant nobody.
  always_comb begin
    logic [2:0] idx;
    idx = '0;
    for (int b = 0; b < 8; b++) begin
      grant[b] = 1'b0;
      win[b]   = '0;
      if (!bus.bank_busy[b]) begin
        for (int k = 0; k < 8; k++) begin
          idx = rr_ptr[b] + 3'(k);
          if (!grant[b] && cand[b][idx]) begin
            grant[b] = 1'b1;
            win[b]   = idx;
          end
        end
      end
    end
  end

  // A port is ready when it is the winner of the bank it targets; nothing is ready during reset.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ready[i] = !rst && cand[sel[i]][i] && grant[sel[i]] && (win[sel[i]] == 3'(i));
    end
  end

  assign bus.req_ready = ready;

  // Advance each bank's pointer past its winner; hold it when the bank is idle or busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 8; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (grant[b]) rr_ptr[b] <= win[b] + 3'd1;
      end
    end
  end

  // Register the winning address and source per bank; ungranted banks drive zeros, not stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      for (int b = 0; b < 8; b++) begin
        out_addr[b] <= '0;
        out_src[b]  <= '0;
      end
    end else begin
      out_valid <= grant;
      for (int b = 0; b < 8; b++) begin
        out_addr[b] <= grant[b] ? addr[win[b]] : '0;
        out_src[b]  <= grant[b] ? win[b] : 3'd0;
      end
    end
  end

  assign bus.bank_valid  = out_valid;
  assign bus.bank_addr_0 = out_addr[0];
  assign bus.bank_addr_1 = out_addr[1];
  assign bus.bank_addr_2 = out_addr[2];
  assign bus.bank_addr_3 = out_addr[3];
  assign bus.bank_addr_4 = out_addr[4];
  assign bus.bank_addr_5 = out_addr[5];
  assign bus.bank_addr_6 = out_addr[6];
  assign bus.bank_addr_7 = out_addr[7];
  assign bus.bank_src_0  = out_src[0];
  assign bus.bank_src_1  = out_src[1];
  assign bus.bank_src_2  = out_src[2];
  assign bus.bank_src_3  = out_src[3];
  assign bus.bank_src_4  = out_src[4];
  assign bus.bank_src_5  = out_src[5];
  assign bus.bank_src_6  = out_src[6];
  assign bus.bank_src_7  = out_src[7];

`ifdef BANK_ARB_PERF_EN
  logic [15:0] stall_cnt [8];

  // Count cycles each port waits with a valid request; clear wins over count, saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) stall_cnt[i] <= '0;
    end else if (perf_clr) begin
      for (int i = 0; i < 8; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.req_valid[i] && !ready[i] && (stall_cnt[i] != 16'hFFFF)) begin
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_perf_out
    assign perf_stall_cnt[16*g +: 16] = stall_cnt[g];
  end
`endif

endmodule

// File: tb/tb_bank_conflict_arbiter.sv
// Testbench for bank_conflict_arbiter: vector table of per-cycle requests with
// expected ready, plus a scoreboard queue of expected registered bank outputs.
`ifndef A_W
`define A_W 16
`endif

module tb_bank_conflict_arbiter;
  localparam int ADDR_W = `A_W;
  localparam int BUS_W  = ADDR_W + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]       drv_valid = '0;
  logic [7:0]       drv_busy  = '0;
  logic [BUS_W-1:0] drv_bus [8];

  bank_conflict_arbiter_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus_if ();

  assign bus_if.req_valid      = drv_valid;
  assign bus_if.bank_busy      = drv_busy;
  assign bus_if.req_addr_bus_0 = drv_bus[0];
  assign bus_if.req_addr_bus_1 = drv_bus[1];
  assign bus_if.req_addr_bus_2 = drv_bus[2];
  assign bus_if.req_addr_bus_3 = drv_bus[3];
  assign bus_if.req_addr_bus_4 = drv_bus[4];
  assign bus_if.req_addr_bus_5 = drv_bus[5];
  assign bus_if.req_addr_bus_6 = drv_bus[6];
  assign bus_if.req_addr_bus_7 = drv_bus[7];

  logic [8*ADDR_W-1:0] obs_addr;
  logic [23:0]         obs_src;
  assign obs_addr = {bus_if.bank_addr_7, bus_if.bank_addr_6, bus_if.bank_addr_5, bus_if.bank_addr_4,
                     bus_if.bank_addr_3, bus_if.bank_addr_2, bus_if.bank_addr_1, bus_if.bank_addr_0};
  assign obs_src  = {bus_if.bank_src_7, bus_if.bank_src_6, bus_if.bank_src_5, bus_if.bank_src_4,
                     bus_if.bank_src_3, bus_if.bank_src_2, bus_if.bank_src_1, bus_if.bank_src_0};

`ifdef BANK_ARB_PERF_EN
  logic         perf_clr = 1'b0;
  logic [127:0] perf_stall_cnt;
`endif

  bank_conflict_arbiter #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .NUM_P(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef BANK_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]          valid;
    logic [8*ADDR_W-1:0] addr;
    logic [23:0]         src;
  } exp_t;

  typedef struct {
    bit         rst_before;
    string      name;
    logic [7:0] valid;
    logic [23:0] sel;
    logic [7:0] busy;
    logic [7:0] exp_ready;
  } vec_t;

  exp_t sb_q [$];
  vec_t tbl [18];
  int n_chk = 0;
  int n_err = 0;
  int grp   = 0;

  function automatic vec_t mk(bit r, string n, logic [7:0] v, logic [23:0] s, logic [7:0] b, logic [7:0] e);
    vec_t t;
    t.rst_before = r; t.name = n; t.valid = v; t.sel = s; t.busy = b; t.exp_ready = e;
    return t;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_for(int g, int i);
    return ADDR_W'(32'h5A00 + 64 * g + 7 * i + 1);
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare registered bank outputs against the oldest pending expectation.
  task automatic check_bank(string name);
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({name, "_bank_valid"}, 256'(bus_if.bank_valid), 256'(e.valid));
      chk({name, "_bank_addr"},  256'(obs_addr), 256'(e.addr));
      chk({name, "_bank_src"},   256'(obs_src), 256'(e.src));
    end
  endtask

  task automatic step(string name, logic [7:0] valid, logic [23:0] sel, logic [7:0] busy, logic [7:0] exp_ready);
    exp_t e;
    int b;
    @(negedge clk);
    drv_valid = valid;
    drv_busy  = busy;
    for (int i = 0; i < 8; i++) drv_bus[i] = {sel[3*i +: 3], addr_for(grp, i)};
    #1;
    check_bank(name);
    chk({name, "_ready"}, 256'(bus_if.req_ready), 256'(exp_ready));
    e = '0;
    for (int i = 0; i < 8; i++) begin
      if (exp_ready[i]) begin
        b = int'(sel[3*i +: 3]);
        e.valid[b] = 1'b1;
        e.addr[b*ADDR_W +: ADDR_W] = addr_for(grp, i);
        e.src[3*b +: 3] = 3'(i);
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    check_bank({name, "_pre"});
    sb_q.delete();
    rst = 1'b1;
    drv_valid = 8'hFF;
    #1;
    chk({name, "_rst_ready"}, 256'(bus_if.req_ready), 256'(0));
    @(negedge clk);
    chk({name, "_rst_valid"}, 256'(bus_if.bank_valid), 256'(0));
    chk({name, "_rst_addr"},  256'(obs_addr), 256'(0));
    chk({name, "_rst_src"},   256'(obs_src), 256'(0));
    drv_valid = '0;
    drv_busy  = '0;
    rst = 1'b0;
    grp++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) drv_bus[i] = '0;

    tbl[0]  = mk(1, "distinct",  8'hFF, 24'o76543210, 8'h00, 8'hFF);
    tbl[1]  = mk(1, "conf_a",    8'h29, 24'o00202002, 8'h00, 8'h01);
    tbl[2]  = mk(0, "conf_b",    8'h29, 24'o00202002, 8'h00, 8'h08);
    tbl[3]  = mk(0, "conf_c",    8'h29, 24'o00202002, 8'h00, 8'h20);
    tbl[4]  = mk(0, "conf_ptr6", 8'h29, 24'o00202002, 8'h00, 8'h01);
    tbl[5]  = mk(1, "wrap_set",  8'h20, 24'o00400000, 8'h00, 8'h20);
    tbl[6]  = mk(0, "wrap_7",    8'h82, 24'o40000040, 8'h00, 8'h80);
    tbl[7]  = mk(0, "wrap_1",    8'h82, 24'o40000040, 8'h00, 8'h02);
    tbl[8]  = mk(1, "busy_a",    8'h23, 24'o00200032, 8'h04, 8'h02);
    tbl[9]  = mk(0, "busy_b",    8'h21, 24'o00200032, 8'h04, 8'h00);
    tbl[10] = mk(0, "busy_c",    8'h21, 24'o00200032, 8'h04, 8'h00);
    tbl[11] = mk(0, "busy_drop", 8'h21, 24'o00200032, 8'h00, 8'h01);
    tbl[12] = mk(0, "busy_hold", 8'h20, 24'o00200032, 8'h04, 8'h00);
    tbl[13] = mk(0, "busy_d",    8'h20, 24'o00200032, 8'h00, 8'h20);
    tbl[14] = mk(0, "idle",      8'h00, 24'o00000000, 8'h00, 8'h00);
    tbl[15] = mk(0, "mixed_a",   8'hFF, 24'o77553322, 8'h00, 8'h55);
    tbl[16] = mk(0, "mixed_b",   8'hFF, 24'o77553322, 8'h00, 8'hAA);
    tbl[17] = mk(0, "idle_end",  8'h00, 24'o00000000, 8'h00, 8'h00);

    foreach (tbl[n]) begin
      if (tbl[n].rst_before) do_reset({tbl[n].name, "_r"});
      step(tbl[n].name, tbl[n].valid, tbl[n].sel, tbl[n].busy, tbl[n].exp_ready);
    end

    // Reset in the middle of contended traffic, asserted between clock edges.
    do_reset("mid");
    step("mid_a", 8'hFF, 24'o33333333, 8'h00, 8'h01);
    step("mid_b", 8'hFF, 24'o33333333, 8'h00, 8'h02);
    @(negedge clk);
    check_bank("mid_c");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_valid", 256'(bus_if.bank_valid), 256'(0));
    chk("mid_async_ready", 256'(bus_if.req_ready), 256'(0));
    chk("mid_async_src",   256'(obs_src), 256'(0));
    sb_q.delete();
    @(negedge clk);
    drv_valid = '0;
    rst = 1'b0;
    step("mid_after_a", 8'hFF, 24'o33333333, 8'h00, 8'h01);
    step("mid_after_b", 8'hFF, 24'o33333333, 8'h00, 8'h02);
    step("mid_idle",    8'h00, 24'o00000000, 8'h00, 8'h00);

`ifdef BANK_ARB_PERF_EN
    do_reset("perf");
    drv_bus[3] = {3'd1, addr_for(grp, 3)};
    drv_valid  = 8'h08;
    drv_busy   = 8'h02;
    repeat (5) @(posedge clk);
    #1;
    chk("perf_stall5", 256'(perf_stall_cnt[16*3 +: 16]), 256'(5));
    chk("perf_other0", 256'(perf_stall_cnt[15:0]), 256'(0));
    @(negedge clk);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    chk("perf_clr", 256'(perf_stall_cnt[16*3 +: 16]), 256'(0));
    repeat (70000) @(posedge clk);
    #1;
    chk("perf_sat", 256'(perf_stall_cnt[16*3 +: 16]), 256'(16'hFFFF));
    drv_valid = '0;
    drv_busy  = '0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
